vram_arbiter: RTL and testbench

Arbiter for the single-port video RAM behind the VGA scan-out path. It shares one synchronous-read RAM between three sources:
- the scan-out requester, driven by the VGA controller's row/col at the 25 MHz pixel rate, with absolute priority;
- a host valid/ready port;
- an internal full-frame clear sequencer.

It converts scan row/col to linear addresses, tags every granted access, and routes returned read data back to the correct source with fixed latency.

---
 rtl/vram_pkg.sv | 9 +
 rtl/vram_clr_seq.sv | 45 ++++
 rtl/vram_arbiter.sv | 91 +++++++++
 tb/tb_vram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and access tags for the video RAM arbiter
package vram_pkg;
    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 12;
    localparam int FRAME_PIX  = DEF_H_RES * DEF_V_RES;
    typedef enum logic [2:0] {NONE, SCAN, SCAN_OOR, HOST_RD, WR} tag_e;
endpackage

// File: rtl/vram_clr_seq.sv
// vram_clr_seq: full-frame clear sequencer writing a latched value to every pixel address
module vram_clr_seq
    import vram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PIX    = FRAME_PIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] start_data,
    input  logic              grant,
    output logic              req,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    typedef enum logic {IDLE, CLEAR} state_e;
    state_e state;

    assign req = state == CLEAR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= CLEAR;
                busy  <= 1'b1;
                addr  <= '0;
                data  <= start_data;
            end
        end else if (grant) begin
            addr <= addr + 1'b1;
            if (addr == ADDR_W'(PIX - 1)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one sync-read video RAM between scan-out, host port and frame clear
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              iClk_50,
    input  logic              iRst,
    input  logic              iScanReq,
    input  logic [9:0]        iScanRow,
    input  logic [9:0]        iScanCol,
    output logic              oScanValid,
    output logic [DATA_W-1:0] oScanData,
    input  logic              iHostValid,
    output logic              oHostReady,
    input  logic              iHostWe,
    input  logic [ADDR_W-1:0] iHostAddr,
    input  logic [DATA_W-1:0] iHostWData,
    output logic              oHostRValid,
    output logic [DATA_W-1:0] oHostRData,
    input  logic              iClrStart,
    input  logic [DATA_W-1:0] iClrData,
    output logic              oClrBusy,
    output logic              oMemEn,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData
);
    logic              scan_in, clr_req, clr_grant, host_go, nxt_en, nxt_we;
    logic [ADDR_W-1:0] scan_addr, clr_addr, nxt_addr;
    logic [DATA_W-1:0] clr_data, nxt_wd;
    tag_e              nxt_tag, tag1, tag2;

    // out-of-frame scan requests leave the RAM slot free but still return a zero pixel
    assign scan_in    = iScanReq && iScanRow < 10'(V_RES) && iScanCol < 10'(H_RES);
    assign scan_addr  = ADDR_W'(iScanRow * H_RES + iScanCol);
    assign oHostReady = !iRst && !iScanReq && !clr_req;
    assign clr_grant  = clr_req && !scan_in;
    assign host_go    = iHostValid && oHostReady;

    assign nxt_en   = scan_in || clr_req || host_go;
    assign nxt_we   = !scan_in && (clr_req || (host_go && iHostWe));
    assign nxt_addr = scan_in ? scan_addr : clr_req ? clr_addr : iHostAddr;
    assign nxt_wd   = clr_req ? clr_data : iHostWData;
    assign nxt_tag  = iScanReq ? (scan_in ? SCAN : SCAN_OOR) :
                      clr_req  ? WR :
                      host_go  ? (iHostWe ? WR : HOST_RD) : NONE;

    vram_clr_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX(H_RES * V_RES)) u_clr (
        .clk       (iClk_50),
        .rst       (iRst),
        .start     (iClrStart),
        .start_data(iClrData),
        .grant     (clr_grant),
        .req       (clr_req),
        .busy      (oClrBusy),
        .addr      (clr_addr),
        .data      (clr_data)
    );

    // tag1 rides with the RAM command, tag2 with the returned read data
    always_ff @(posedge iClk_50) begin
        if (iRst) begin
            oMemEn      <= 1'b0;
            oMemWe      <= 1'b0;
            oMemAddr    <= '0;
            oMemWData   <= '0;
            tag1        <= NONE;
            tag2        <= NONE;
            oScanValid  <= 1'b0;
            oScanData   <= '0;
            oHostRValid <= 1'b0;
            oHostRData  <= '0;
        end else begin
            oMemEn      <= nxt_en;
            oMemWe      <= nxt_we;
            oMemAddr    <= nxt_addr;
            oMemWData   <= nxt_wd;
            tag1        <= nxt_tag;
            tag2        <= tag1;
            oScanValid  <= tag2 == SCAN || tag2 == SCAN_OOR;
            oScanData   <= tag2 == SCAN ? iMemRData : '0;
            oHostRValid <= tag2 == HOST_RD;
            if (tag2 == HOST_RD) oHostRData <= iMemRData;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random and directed stimulus checked against a behavioural arbiter model
module tb_vram_arbiter;
    localparam int H = 16, V = 8, AW = 8, DW = 12, PIX = H * V;

    logic          iClk_50, iRst, iScanReq, iHostValid, iHostWe, iClrStart;
    logic [9:0]    iScanRow, iScanCol;
    logic [AW-1:0] iHostAddr;
    logic [DW-1:0] iHostWData, iClrData, iMemRData;
    logic          oScanValid, oHostReady, oHostRValid, oClrBusy, oMemEn, oMemWe;
    logic [DW-1:0] oScanData, oHostRData, oMemWData;
    logic [AW-1:0] oMemAddr;

    vram_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .iClk_50(iClk_50), .iRst(iRst),
        .iScanReq(iScanReq), .iScanRow(iScanRow), .iScanCol(iScanCol),
        .oScanValid(oScanValid), .oScanData(oScanData),
        .iHostValid(iHostValid), .oHostReady(oHostReady), .iHostWe(iHostWe),
        .iHostAddr(iHostAddr), .iHostWData(iHostWData),
        .oHostRValid(oHostRValid), .oHostRData(oHostRData),
        .iClrStart(iClrStart), .iClrData(iClrData), .oClrBusy(oClrBusy),
        .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
        .iMemRData(iMemRData)
    );

    initial iClk_50 = 1'b0;
    always #10 iClk_50 = ~iClk_50;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iClk_50);
        #1;
    endtask

    logic [DW-1:0] ram [256];
    logic [DW-1:0] shadow [256];

    // RAM behind the arbiter: one-cycle synchronous read
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = DW'($urandom);
            shadow[i] = ram[i];
        end
        iMemRData = '0;
        forever begin
            @(posedge iClk_50);
            if (oMemEn === 1'b1) begin
                if (oMemWe) ram[oMemAddr] = oMemWData;
                else iMemRData <= ram[oMemAddr];
            end
        end
    end

    typedef struct packed {
        bit en, we, sv, hv, rst;
        bit [AW-1:0] a;
        bit [DW-1:0] d, sd, hd;
    } exp_t;
    exp_t ex [8];
    int cyc = 0;
    bit chk_on = 0, m_busy = 0;
    int m_cnt = 0;
    logic [DW-1:0] m_val, hold;

    // reference model: one access per cycle by priority, results scheduled 1 and 3 cycles ahead
    initial begin
        int n1, n3, lin;
        bit was;
        for (int i = 0; i < 8; i++) ex[i] = '0;
        forever begin
            @(posedge iClk_50);
            n1 = (cyc + 1) % 8;
            n3 = (cyc + 3) % 8;
            if (iRst) begin
                for (int i = 0; i < 8; i++) ex[i] = '0;
                ex[n1].rst = 1;
                m_busy = 0;
                chk_on = 1;
            end else begin
                was = m_busy;
                if (iScanReq && iScanRow < V && iScanCol < H) begin
                    lin = int'(iScanRow) * H + int'(iScanCol);
                    ex[n1].en = 1;
                    ex[n1].a  = AW'(lin % 256);
                    ex[n3].sv = 1;
                    ex[n3].sd = shadow[lin % 256];
                end else begin
                    if (iScanReq) begin
                        ex[n3].sv = 1;
                        ex[n3].sd = '0;
                    end
                    if (m_busy) begin
                        ex[n1].en = 1;
                        ex[n1].we = 1;
                        ex[n1].a  = AW'(m_cnt);
                        ex[n1].d  = m_val;
                        shadow[m_cnt] = m_val;
                        m_cnt++;
                        if (m_cnt == PIX) m_busy = 0;
                    end else if (iHostValid && !iScanReq) begin
                        ex[n1].en = 1;
                        ex[n1].we = iHostWe;
                        ex[n1].a  = iHostAddr;
                        if (iHostWe) begin
                            ex[n1].d = iHostWData;
                            shadow[iHostAddr] = iHostWData;
                        end else begin
                            ex[n3].hv = 1;
                            ex[n3].hd = shadow[iHostAddr];
                        end
                    end
                end
                if (!was && iClrStart) begin
                    m_busy = 1;
                    m_cnt  = 0;
                    m_val  = iClrData;
                end
            end
            cyc++;
        end
    end

    initial begin
        int s;
        hold = '0;
        forever begin
            @(negedge iClk_50);
            s = cyc % 8;
            if (chk_on) begin
                if (ex[s].rst) hold = '0;
                check("mem_en", 32'(oMemEn), 32'(ex[s].en));
                if (ex[s].en) begin
                    check("mem_we", 32'(oMemWe), 32'(ex[s].we));
                    check("mem_addr", 32'(oMemAddr), 32'(ex[s].a));
                    if (ex[s].we) check("mem_wdata", 32'(oMemWData), 32'(ex[s].d));
                end
                check("scan_valid", 32'(oScanValid), 32'(ex[s].sv));
                if (ex[s].sv) check("scan_data", 32'(oScanData), 32'(ex[s].sd));
                check("host_rvalid", 32'(oHostRValid), 32'(ex[s].hv));
                if (ex[s].hv) hold = ex[s].hd;
                check("host_rdata", 32'(oHostRData), 32'(hold));
                check("clr_busy", 32'(oClrBusy), 32'(m_busy));
                check("host_ready", 32'(oHostReady), 32'(!iRst && !iScanReq && !m_busy));
            end
            ex[s] = '0;
        end
    end

    initial begin
        int rdy_cnt, cnt, bad;
        bit done;
        iRst = 1; iScanReq = 0; iScanRow = '0; iScanCol = '0;
        iHostValid = 0; iHostWe = 0; iHostAddr = '0; iHostWData = '0;
        iClrStart = 0; iClrData = '0;
        repeat (3) step();
        @(negedge iClk_50);
        check("ready_in_reset", 32'(oHostReady), 32'd0);
        step();
        iRst = 0;
        @(negedge iClk_50);
        check("rst_mem_en", 32'(oMemEn), 32'd0);
        check("rst_scan_valid", 32'(oScanValid), 32'd0);
        check("rst_host_rdata", 32'(oHostRData), 32'd0);
        check("rst_clr_busy", 32'(oClrBusy), 32'd0);
        step();
        iHostValid = 1; iHostWe = 1; iHostAddr = 8'd5; iHostWData = 12'hABC;
        @(negedge iClk_50);
        check("host_ready_idle", 32'(oHostReady), 32'd1);
        step();
        iHostWe = 0;
        step();
        iHostValid = 0;
        @(negedge iClk_50);
        check("rd_cmd_addr", 32'(oMemAddr), 32'd5);
        check("rd_cmd_we", 32'(oMemWe), 32'd0);
        step();
        @(negedge iClk_50);
        check("rd_not_early", 32'(oHostRValid), 32'd0);
        step();
        @(negedge iClk_50);
        check("rd_valid_n3", 32'(oHostRValid), 32'd1);
        check("rd_data_abc", 32'(oHostRData), 32'hABC);
        step();
        iScanReq = 1; iScanRow = 10'd1; iScanCol = 10'd2;
        step();
        iScanReq = 0;
        @(negedge iClk_50);
        check("scan_addr_18", 32'(oMemAddr), 32'd18);
        check("scan_en", 32'(oMemEn), 32'd1);
        step();
        step();
        @(negedge iClk_50);
        check("scan_valid_n3", 32'(oScanValid), 32'd1);
        check("scan_data_ram", 32'(oScanData), 32'(ram[18]));
        step();
        iScanReq = 1; iScanRow = 10'(V); iScanCol = 10'd0;
        step();
        iScanReq = 0;
        @(negedge iClk_50);
        check("oor_no_en", 32'(oMemEn), 32'd0);
        step();
        step();
        @(negedge iClk_50);
        check("oor_valid", 32'(oScanValid), 32'd1);
        check("oor_zero", 32'(oScanData), 32'd0);
        step();
        iScanReq = 1; iScanRow = '0; iScanCol = '0; iHostValid = 1; iHostWe = 0;
        @(negedge iClk_50);
        check("scan_blocks_host", 32'(oHostReady), 32'd0);
        step();
        rdy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            iScanReq = (k % 2 == 0);
            iHostAddr = AW'(k);
            @(negedge iClk_50);
            if (oHostReady) rdy_cnt++;
            step();
        end
        iScanReq = 0; iHostValid = 0;
        check("gap_accepts", 32'(rdy_cnt), 32'd5);
        iClrStart = 1; iClrData = 12'h0F0;
        step();
        iClrStart = 0;
        done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            iScanReq = (k % 2 == 0);
            iScanRow = 10'($urandom % V);
            iScanCol = 10'($urandom % H);
            iClrStart = (k == 20);
            iClrData = (k == 20) ? 12'h111 : 12'h0F0;
            @(negedge iClk_50);
            done = !oClrBusy;
            step();
        end
        iScanReq = 0; iClrStart = 0;
        check("clr_scan_done", 32'(done), 32'd1);
        step();
        bad = 0;
        for (int i = 0; i < PIX; i++) if (ram[i] !== 12'h0F0) bad++;
        check("clr_all_0f0", 32'(bad), 32'd0);
        iClrStart = 1; iClrData = 12'h333;
        step();
        iClrStart = 0;
        cnt = 0;
        done = 0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge iClk_50);
            if (oClrBusy) cnt++;
            else done = 1;
            step();
        end
        check("clr_duration", 32'(cnt), 32'(PIX));
        iHostValid = 1; iHostWe = 0; iHostAddr = 8'd3; iClrStart = 1; iClrData = 12'h222;
        step();
        iHostValid = 0; iClrStart = 0; iRst = 1;
        step();
        iRst = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge iClk_50);
            check("post_rst_rvalid", 32'(oHostRValid), 32'd0);
            check("post_rst_busy", 32'(oClrBusy), 32'd0);
            step();
        end
        for (int k = 0; k < 4000; k++) begin
            iScanReq   = ($urandom % 10) < 4;
            iScanRow   = 10'($urandom % 10);
            iScanCol   = 10'($urandom % 18);
            iHostValid = $urandom % 2;
            iHostWe    = $urandom % 2;
            iHostAddr  = AW'($urandom);
            iHostWData = DW'($urandom);
            iClrStart  = ($urandom % 150) == 0;
            iClrData   = DW'($urandom);
            iRst       = ($urandom % 700) == 0;
            step();
        end
        iScanReq = 0; iHostValid = 0; iClrStart = 0; iRst = 0;
        repeat (6) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
